// File: rtl/ahb_subordinate_bridge_pkg.sv
// Shared encodings for the AHB subordinate bridge: HTRANS, HSIZE, HRESP
// codes and the bridge FSM state values.
package ahb_subordinate_bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Bridge FSM state, kept as plain constants for legacy tool flows.
    typedef logic [1:0] bridge_state_t;
    localparam bridge_state_t ST_IDLE = 2'd0;
    localparam bridge_state_t ST_DATA = 2'd1;
    localparam bridge_state_t ST_ERR1 = 2'd2;
    localparam bridge_state_t ST_ERR2 = 2'd3;

    // True for transfer types that carry an address phase to be serviced.
    function automatic logic is_active_trans(input logic [1:0] htrans);
        logic active;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/ahb_xfer_check.sv
// Combinational legality check of an address phase: size must be at most a
// word and the address must be naturally aligned to that size.
module ahb_xfer_check
    import ahb_subordinate_bridge_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_lo_i,
    output logic       legal_o
);

    // Alignment rule per transfer size; anything wider than a word is illegal.
    always_comb begin
        // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
        legal_o = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: legal_o = 1'b1;
            HSIZE_HALF: legal_o = (addr_lo_i[0] == 1'b0);
            HSIZE_WORD: legal_o = (addr_lo_i == 2'b00);
            default:    legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ahb_subordinate_bridge.sv
// AHB subordinate to simple peripheral bridge. One address-phase register
// set plus a four-state FSM (IDLE, DATA, ERR1, ERR2). Peripheral strobes and
// AHB responses are decoded combinationally from the FSM state.
module ahb_subordinate_bridge
    import ahb_subordinate_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    HSEL,
    input  logic                    HREADY,
    input  logic                    HWRITE,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HSIZE,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic [DATA_WIDTH/8-1:0] HWSTRB,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    wen,
    output logic                    ren,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] strobe,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    error,
    input  logic                    request_stall
);

    bridge_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic                  legal;
    logic                  accept;

    ahb_xfer_check u_xfer_check (
        .hsize_i   (HSIZE),
        .addr_lo_i (HADDR[1:0]),
        .legal_o   (legal)
    );

    // Address phases are only sampled while this subordinate is itself ready.
    assign accept = HSEL && HREADY && is_active_trans(HTRANS) && HREADYOUT;
    assign addr   = addr_q;

    // Bus response and peripheral strobes decoded from the current state.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        wen       = 1'b0;
        ren       = 1'b0;
        wdata     = '0;
        strobe    = '0;
        case (state_q)
            ST_DATA: begin
                wen    = write_q;
                ren    = !write_q;
                HRDATA = rdata;
                if (write_q) begin
                    wdata  = HWDATA;
                    strobe = HWSTRB;
                end
                // A stalled peripheral's error line is not meaningful yet.
                HREADYOUT = !request_stall && !error;
                HRESP     = (!request_stall && error) ? HRESP_ERROR : HRESP_OKAY;
            end
            ST_ERR1: begin
                HRESP     = HRESP_ERROR;
                HREADYOUT = 1'b0;
            end
            ST_ERR2: begin
                HRESP = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    // Next-state logic and capture of an accepted address phase.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        if (accept) begin
            addr_d  = HADDR;
            write_d = HWRITE;
        end
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = accept ? (legal ? ST_DATA : ST_ERR1) : ST_IDLE;
            end
            ST_DATA: begin
                if (request_stall) begin
                    state_d = ST_DATA;
                end else if (error) begin
                    state_d = ST_ERR2;
                end else begin
                    state_d = accept ? (legal ? ST_DATA : ST_ERR1) : ST_IDLE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and address-phase registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
        end
    end

endmodule
